// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath width and data-memory geometry.
package mips_pkg;

    // Datapath word width.
    localparam int unsigned DATA_BITS = 32;

    // Data-memory word-index width (1024 words).
    localparam int unsigned DMEM_ADDR_BITS = 10;

    // Byte-to-word shift: low address bits dropped to form a word index.
    localparam int unsigned WORD_OFFSET = 2;

endpackage : mips_pkg

// File: rtl/data_ram.sv
// Synchronous single-port RAM with a registered, write-first read port.
// Contents start at zero and are never cleared by reset.
module data_ram
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_BITS = mips_pkg::DMEM_ADDR_BITS,
    parameter int unsigned DATA_BITS = mips_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    // Declaration-time zero fill keeps every location defined from time zero.
    logic [DATA_BITS-1:0] mem [DEPTH] = '{default: '0};

    // Store on we; read every edge, forwarding din when the same word is written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout      <= mem[addr];
        end
    end

endmodule : data_ram

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte address to word index, reset-gated store, and a
// registered load result that reads as zero after any reset edge.
module mem_stage #(
    parameter int unsigned ADDR_BITS = mips_pkg::DMEM_ADDR_BITS,
    parameter int unsigned DATA_BITS = mips_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Mem_WrEn,
    input  logic [31:0]          ALU_MEM_Addr,
    input  logic [DATA_BITS-1:0] MEM_DataIn,
    output logic [DATA_BITS-1:0] MEM_DataOut
);

    import mips_pkg::*;

    logic [ADDR_BITS-1:0] wordIdx;
    logic                 ramWe;
    logic [DATA_BITS-1:0] ramDout;
    logic                 outClr;

    // Byte offset and bits above 4 KiB are dropped: aligned, aliasing accesses.
    assign wordIdx = ALU_MEM_Addr[WORD_OFFSET +: ADDR_BITS];

    // Address bits that intentionally take no part in the access.
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0,
                              ALU_MEM_Addr[31:WORD_OFFSET+ADDR_BITS],
                              ALU_MEM_Addr[WORD_OFFSET-1:0]};

    // A store on a reset edge is dropped.
    assign ramWe = Mem_WrEn & rst_n;

    data_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) uDataRam (
        .clk  (clk),
        .we   (ramWe),
        .addr (wordIdx),
        .din  (MEM_DataIn),
        .dout (ramDout)
    );

    // Remember that the last edge was a reset edge so the in-flight load is discarded.
    always_ff @(posedge clk) begin
        outClr <= ~rst_n;
    end

    // Selects between two flop outputs only; no input reaches MEM_DataOut combinationally.
    assign MEM_DataOut = outClr ? '0 : ramDout;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares one result per clock.
module tb_mem_stage;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        Mem_WrEn     = 1'b0;
    logic [31:0] ALU_MEM_Addr = '0;
    logic [31:0] MEM_DataIn   = '0;
    logic [31:0] MEM_DataOut;

    mem_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Mem_WrEn     (Mem_WrEn),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_DataOut  (MEM_DataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] expVal;
        string       tag;
    } exp_t;

    exp_t sbQ[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    // One access per cycle; expected MEM_DataOut after this edge is queued.
    task automatic access(input logic r, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] e, input string tag);
        @(negedge clk);
        rst_n        = r;
        Mem_WrEn     = we;
        ALU_MEM_Addr = a;
        MEM_DataIn   = d;
        @(posedge clk);
        sbQ.push_back('{expVal: e, tag: tag});
    endtask

    // Monitor: every edge produces a result, checked half a cycle later.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            cur = sbQ.pop_front();
            checks++;
            if (MEM_DataOut !== cur.expVal) begin
                failures++;
                $display("FAIL %s: got %08h expected %08h", cur.tag, MEM_DataOut, cur.expVal);
            end
        end
    end

    initial begin
        // Reset with a pending store: output zero, store suppressed.
        access(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 32'h0, "rst_edge1");
        access(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 32'h0, "rst_edge2");
        access(1'b1, 1'b0, 32'h4, 32'h0,         32'h0, "rst_store_dropped");

        // Write sweep (write-first shows new data immediately).
        access(1'b1, 1'b1, 32'h4,  32'd1, 32'd1, "wr_0x4");
        access(1'b1, 1'b1, 32'h8,  32'd2, 32'd2, "wr_0x8");
        access(1'b1, 1'b1, 32'hC,  32'd3, 32'd3, "wr_0xC");
        access(1'b1, 1'b1, 32'h10, 32'd4, 32'd4, "wr_0x10");

        // Read sweep, with junk on the data bus while the enable is low.
        access(1'b1, 1'b0, 32'h4,  32'hBAD0_0001, 32'd1, "rd_0x4");
        access(1'b1, 1'b0, 32'h8,  32'hBAD0_0002, 32'd2, "rd_0x8");
        access(1'b1, 1'b0, 32'hC,  32'hBAD0_0003, 32'd3, "rd_0xC");
        access(1'b1, 1'b0, 32'h10, 32'hBAD0_0004, 32'd4, "rd_0x10");
        access(1'b1, 1'b0, 32'h4,  32'h0,         32'd1, "rd_0x4_again");

        // Alignment and 4 KiB aliasing.
        access(1'b1, 1'b1, 32'h22,   32'hA5A5_A5A5, 32'hA5A5_A5A5, "wr_0x22");
        access(1'b1, 1'b0, 32'h20,   32'h0,         32'hA5A5_A5A5, "rd_0x20");
        access(1'b1, 1'b0, 32'h1020, 32'h0,         32'hA5A5_A5A5, "rd_alias_0x1020");
        access(1'b1, 1'b0, 32'h23,   32'h0,         32'hA5A5_A5A5, "rd_0x23");

        // Read-during-write to the same word.
        access(1'b1, 1'b0, 32'h8, 32'h0,         32'd2,         "rd_0x8_before");
        access(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rdw_0x8");
        access(1'b1, 1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF, "rd_0x8_after");

        // Boundary words and their neighbours.
        access(1'b1, 1'b1, 32'hFFC,       32'h1234_5678, 32'h1234_5678, "wr_top");
        access(1'b1, 1'b1, 32'h0,         32'h9,         32'h9,         "wr_bottom");
        access(1'b1, 1'b0, 32'hFFC,       32'h0,         32'h1234_5678, "rd_top");
        access(1'b1, 1'b0, 32'h0,         32'h0,         32'h9,         "rd_bottom");
        access(1'b1, 1'b0, 32'hFF8,       32'h0,         32'h0,         "rd_below_top");
        access(1'b1, 1'b0, 32'h4,         32'h0,         32'd1,         "rd_above_bottom");
        access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, "rd_top_alias_hi");

        // Reset pulse retains RAM contents.
        access(1'b0, 1'b0, 32'hC, 32'h0, 32'h0, "rst_pulse");
        access(1'b1, 1'b0, 32'hC, 32'h0, 32'd3, "rd_0xC_retained");

        // Reset mid-sequence with a store on the same edge: store dropped.
        access(1'b0, 1'b1, 32'h10, 32'h77, 32'h0,  "rst_with_store");
        access(1'b1, 1'b0, 32'h10, 32'h0,  32'd4,  "rd_0x10_kept");

        // Drain: monitor must have consumed every expectation.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("FAIL drain: pending %0d expected 0", sbQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, pending %0d expected 0", sbQ.size());
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_stage
